// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multicycle sequencer and the ARM-style datapath.
// master: the sequencer side; slave: the datapath/memory side.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned ALU_SEL_W = 4
);
    logic [31:0]          instr;
    logic [3:0]           flags;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_wen;
    logic                 adr_src;
    logic                 ir_wen;
    logic                 pc_wen;
    logic                 pc_src;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 reg_wen;
    logic                 result_src;
    logic                 flags_wen;
    logic                 instr_done;
    logic                 fault;

    modport master (
        input  instr, flags, mem_ready,
        output mem_req, mem_wen, adr_src, ir_wen, pc_wen, pc_src, alu_src_a, alu_src_b,
               alu_sel, reg_wen, result_src, flags_wen, instr_done, fault
    );

    modport slave (
        output instr, flags, mem_ready,
        input  mem_req, mem_wen, adr_src, ir_wen, pc_wen, pc_src, alu_src_a, alu_src_b,
               alu_sel, reg_wen, result_src, flags_wen, instr_done, fault
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle sequencer: fetch, condition check, then per-class ALU/memory/branch steps.
// Outputs are Moore decodes of state + instr; only mem_ready gates strobes in FETCH/MEM_WR.
module multicycle_ctrl_fsm #(
    parameter int unsigned ALU_SEL_W   = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StReset, StFetch, StDecode, StExec, StAluWb, StMemAdr,
        StMemRd, StMemLdWb, StMemWr, StBranch, StHalt
    } state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic            fault_q;
    logic            cond_pass;
    logic            is_cmp;
    logic            timeout_hit;
    logic [3:0]      dp_alu;

    logic [3:0] cond;
    logic       n_f, z_f, c_f, v_f;
    assign cond = bus.instr[31:28];
    assign {n_f, z_f, c_f, v_f} = bus.flags;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dp_alu = 4'd0;
        case (bus.instr[24:21])
            4'b0000, 4'b1000: dp_alu = 4'd7;
            4'b0001, 4'b1001: dp_alu = 4'd8;
            4'b0010, 4'b1010: dp_alu = 4'd2;
            4'b0011:          dp_alu = 4'd3;
            4'b0100, 4'b1011: dp_alu = 4'd0;
            4'b0101:          dp_alu = 4'd1;
            4'b0110:          dp_alu = 4'd4;
            4'b0111:          dp_alu = 4'd5;
            4'b1100:          dp_alu = 4'd9;
            4'b1101:          dp_alu = 4'd6;
            4'b1110:          dp_alu = 4'd11;
            default:          dp_alu = 4'd10;
        endcase
    end

    // TST/TEQ/CMP/CMN only update flags and retire from EXEC
    assign is_cmp      = (bus.instr[24:23] == 2'b10);
    assign timeout_hit = (MEM_TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StReset;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                StReset: state <= StFetch;
                StFetch, StMemRd, StMemWr: begin
                    if (bus.mem_ready) begin
                        state <= (state == StFetch) ? StDecode :
                                 (state == StMemRd) ? StMemLdWb : StFetch;
                    end else if (timeout_hit) begin
                        state   <= StHalt;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StDecode: begin
                    if (!cond_pass) begin
                        state <= StFetch;
                    end else begin
                        case (bus.instr[27:26])
                            2'b00:   state <= StExec;
                            2'b01:   state <= StMemAdr;
                            2'b10:   state <= StBranch;
                            default: state <= StFetch;
                        endcase
                    end
                end
                StExec:    state <= is_cmp ? StFetch : StAluWb;
                StAluWb:   state <= StFetch;
                StMemAdr:  state <= bus.instr[20] ? StMemRd : StMemWr;
                StMemLdWb: state <= StFetch;
                StBranch:  state <= StFetch;
                StHalt:    state <= StHalt;
                default:   state <= StReset;
            endcase
        end
    end

    logic       mem_req, mem_wen, adr_src, ir_wen, pc_wen, pc_src, alu_src_a, alu_src_b;
    logic       reg_wen, result_src, flags_wen, instr_done;
    logic [3:0] alu_code;

    always_comb begin
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        adr_src    = 1'b0;
        ir_wen     = 1'b0;
        pc_wen     = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_code   = 4'd0;
        reg_wen    = 1'b0;
        result_src = 1'b0;
        flags_wen  = 1'b0;
        instr_done = 1'b0;
        case (state)
            StFetch: begin
                mem_req = 1'b1;
                ir_wen  = bus.mem_ready;
                pc_wen  = bus.mem_ready;
            end
            StDecode:  instr_done = !cond_pass || (bus.instr[27:26] == 2'b11);
            StExec: begin
                alu_code   = dp_alu;
                flags_wen  = bus.instr[20] | is_cmp;
                instr_done = is_cmp;
            end
            StAluWb: begin
                alu_code   = dp_alu;
                reg_wen    = 1'b1;
                instr_done = 1'b1;
            end
            StMemAdr:  alu_code = bus.instr[23] ? 4'd0 : 4'd2;
            StMemRd: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemLdWb: begin
                reg_wen    = 1'b1;
                result_src = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_req    = 1'b1;
                mem_wen    = 1'b1;
                adr_src    = 1'b1;
                instr_done = bus.mem_ready;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 1'b1;
                pc_wen     = 1'b1;
                pc_src     = 1'b1;
                reg_wen    = bus.instr[24];
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_wen    = mem_wen;
    assign bus.adr_src    = adr_src;
    assign bus.ir_wen     = ir_wen;
    assign bus.pc_wen     = pc_wen;
    assign bus.pc_src     = pc_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_sel    = ALU_SEL_W'(alu_code);
    assign bus.reg_wen    = reg_wen;
    assign bus.result_src = result_src;
    assign bus.flags_wen  = flags_wen;
    assign bus.instr_done = instr_done;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-by-cycle vector bench for the multicycle sequencer, plus timeout and mid-access reset runs.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.ALU_SEL_W(4)) bus ();

    multicycle_ctrl_fsm #(
        .ALU_SEL_W  (4),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_wen;
        logic       adr_src;
        logic       ir_wen;
        logic       pc_wen;
        logic       pc_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_sel;
        logic       reg_wen;
        logic       result_src;
        logic       flags_wen;
        logic       instr_done;
    } ctrl_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        logic        ready;
        ctrl_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic ctrl_t cw(input logic mr, mw, as, ir, pw, ps, sa, sb,
                                 input logic [3:0] al, input logic rw, rs, fw, dn);
        return '{mr, mw, as, ir, pw, ps, sa, sb, al, rw, rs, fw, dn};
    endfunction

    function automatic ctrl_t act();
        return cw(bus.mem_req, bus.mem_wen, bus.adr_src, bus.ir_wen, bus.pc_wen, bus.pc_src,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.reg_wen, bus.result_src,
                  bus.flags_wen, bus.instr_done);
    endfunction

    task automatic add(input logic [31:0] i, input logic [3:0] f, input logic r, input ctrl_t e);
        vec_t v;
        v.instr = i;
        v.flags = f;
        v.ready = r;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic chk_ctrl(input string name, input ctrl_t exp);
        ctrl_t a;
        a = act();
        n_checks++;
        if (a !== exp) begin
            n_fail++;
            $display("FAIL %s: ctrl got %h expected %h", name, a, exp);
        end
    endtask

    task automatic chk_fault(input string name, input logic exp);
        n_checks++;
        if (bus.fault !== exp) begin
            n_fail++;
            $display("FAIL %s: fault got %b expected %b", name, bus.fault, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [3:0] f, input logic r);
        bus.instr     = i;
        bus.flags     = f;
        bus.mem_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD   = 32'hE081_1002;
    localparam logic [31:0] CMP   = 32'hE151_0002;
    localparam logic [31:0] BEQ   = 32'h0A00_0000;
    localparam logic [31:0] BL    = 32'hEB00_0010;
    localparam logic [31:0] ORRGT = 32'hC181_0002;
    localparam logic [31:0] MVNLT = 32'hB1F0_0000;
    localparam logic [31:0] NEVER = 32'hF000_0000;
    localparam logic [31:0] NOP11 = 32'hEC00_0000;
    localparam logic [31:0] STRU  = 32'hE581_2004;
    localparam logic [31:0] STRD  = 32'hE501_2004;
    localparam logic [31:0] LDR   = 32'hE591_2004;

    initial begin
        ctrl_t z0, ft, fw, mrd;
        z0  = '0;
        ft  = cw(1, 0, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        fw  = cw(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        mrd = cw(1, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        add(ADD, 4'h0, 1, z0);
        add(ADD, 4'h0, 0, fw);
        add(ADD, 4'h0, 1, ft);
        add(ADD, 4'h0, 0, z0);
        add(ADD, 4'h0, 1, z0);
        add(ADD, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1));
        add(CMP, 4'h0, 1, ft);
        add(CMP, 4'h0, 1, z0);
        add(CMP, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 1, 1));
        add(BEQ, 4'h0, 1, ft);
        add(BEQ, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(BEQ, 4'h4, 1, ft);
        add(BEQ, 4'h4, 1, z0);
        add(BEQ, 4'h4, 1, cw(0, 0, 0, 0, 1, 1, 1, 1, 4'd0, 0, 0, 0, 1));
        add(BL, 4'h0, 1, ft);
        add(BL, 4'h0, 1, z0);
        add(BL, 4'h0, 1, cw(0, 0, 0, 0, 1, 1, 1, 1, 4'd0, 1, 0, 0, 1));
        add(ORRGT, 4'h0, 1, ft);
        add(ORRGT, 4'h0, 1, z0);
        add(ORRGT, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0, 0));
        add(ORRGT, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 1, 0, 0, 1));
        add(MVNLT, 4'h9, 1, ft);
        add(MVNLT, 4'h9, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(MVNLT, 4'h8, 1, ft);
        add(MVNLT, 4'h8, 1, z0);
        add(MVNLT, 4'h8, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd10, 0, 0, 1, 0));
        add(MVNLT, 4'h8, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd10, 1, 0, 0, 1));
        add(NEVER, 4'hF, 1, ft);
        add(NEVER, 4'hF, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(NOP11, 4'h0, 1, ft);
        add(NOP11, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(STRU, 4'h0, 1, ft);
        add(STRU, 4'h0, 1, z0);
        add(STRU, 4'h0, 1, z0);
        add(STRU, 4'h0, 1, cw(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(STRD, 4'h0, 1, ft);
        add(STRD, 4'h0, 1, z0);
        add(STRD, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 0, 0));
        add(STRD, 4'h0, 0, cw(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0));
        add(STRD, 4'h0, 1, cw(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
        add(LDR, 4'h0, 1, ft);
        add(LDR, 4'h0, 1, z0);
        add(LDR, 4'h0, 1, z0);
        // three stalls stay below the timeout of four
        add(LDR, 4'h0, 0, mrd);
        add(LDR, 4'h0, 0, mrd);
        add(LDR, 4'h0, 0, mrd);
        add(LDR, 4'h0, 1, mrd);
        add(LDR, 4'h0, 1, cw(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 1));

        rst_n = 1'b0;
        drive(32'h0, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk_ctrl("reset_outputs", z0);
        chk_fault("reset_fault", 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].flags, vecs[i].ready);
            @(negedge clk);
            chk_ctrl($sformatf("vec%0d", i), vecs[i].exp);
            chk_fault($sformatf("vec%0d_fault", i), 1'b0);
            next_cycle();
        end

        // memory never answers a fetch: four waits then HALT
        drive(ADD, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_ctrl($sformatf("timeout_wait%0d", i), fw);
            chk_fault($sformatf("timeout_wait%0d_fault", i), 1'b0);
            next_cycle();
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_ctrl($sformatf("halt%0d", i), z0);
            chk_fault($sformatf("halt%0d_fault", i), 1'b1);
            next_cycle();
        end
        rst_n = 1'b0;
        next_cycle();
        chk_ctrl("halt_reset_outputs", z0);
        chk_fault("halt_reset_fault", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ctrl("post_reset_idle", z0);
        next_cycle();

        // reset in the middle of a stalled load aborts the access
        drive(LDR, 4'h0, 1'b1);
        @(negedge clk);
        chk_ctrl("mid_fetch", ft);
        repeat (3) next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk_ctrl("mid_memrd", mrd);
        rst_n = 1'b0;
        next_cycle();
        chk_ctrl("mid_abort", z0);
        chk_fault("mid_abort_fault", 1'b0);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_ctrl("mid_refetch", fw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
